// File: rtl/video_line_fetch.sv
// Line-fetch stage behind the video timing generator: requests one line per visible line,
// buffers it in a FIFO and emits pixels aligned with the 1-cycle delayed sync/den.
module video_line_fetch #(
  parameter int unsigned         PIXEL_W       = 24,
  parameter int unsigned         H_VISIBLE     = 1920,
  parameter int unsigned         FIFO_DEPTH    = 4096,
  parameter bit                  VSYNC_POL     = 1'b1,
  parameter logic [PIXEL_W-1:0]  UNDERFLOW_RGB = PIXEL_W'(24'hFF00FF)
) (
  input  logic                           pixel_clock,
  input  logic                           rst,
  input  logic                           video_hsync,
  input  logic                           video_vsync,
  input  logic                           video_den,
  input  logic                           video_line_start,
  output logic                           line_req,
  output logic [13:0]                    line_req_y,
  input  logic                           line_req_ack,
  input  logic                           in_valid,
  input  logic [PIXEL_W-1:0]             in_data,
  output logic                           in_ready,
  output logic                           out_hsync,
  output logic                           out_vsync,
  output logic                           out_den,
  output logic [PIXEL_W-1:0]             out_data,
  output logic                           underflow,
  input  logic                           underflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned YW = 14;
  localparam int unsigned CW = 14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [CW-1:0]       pix_cnt;
  logic [CW-1:0]       pix_cnt_next;
  logic [YW-1:0]       line_cnt;
  logic [YW-1:0]       line_cnt_next;
  logic [YW-1:0]       line_req_y_next;
  logic                line_req_next;
  logic                in_ready_next;
  logic [LW-1:0]       wr_ptr;
  logic [LW-1:0]       wr_ptr_next;
  logic [LW-1:0]       rd_ptr;
  logic [LW-1:0]       rd_ptr_next;
  logic [LW-1:0]       level_next;
  logic                vs_prev;
  logic                vs_active;
  logic                frame_start;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [PIXEL_W-1:0]  out_data_next;
  logic                underflow_next;

  logic [PIXEL_W-1:0]  mem [FIFO_DEPTH];

  // Next-state, FIFO pointer and output computation
  always_comb begin
    state_next      = state;
    pix_cnt_next    = pix_cnt;
    line_cnt_next   = line_cnt;
    line_req_y_next = line_req_y;

    vs_active   = (video_vsync == VSYNC_POL);
    frame_start = vs_active & ~vs_prev;
    fifo_empty  = (fifo_level == '0);
    push        = in_valid & in_ready & ~frame_start;
    pop         = video_den & ~fifo_empty;
    wr_ptr_next = wr_ptr + LW'(push);
    rd_ptr_next = rd_ptr + LW'(pop);

    if (frame_start) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      state_next    = ST_IDLE;
      line_cnt_next = '0;
    end else begin
      if (video_line_start) begin
        line_cnt_next = line_cnt + YW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (video_line_start) begin
            state_next      = ST_REQ;
            line_req_y_next = line_cnt;
          end
        end
        ST_REQ: begin
          if (line_req_ack) begin
            state_next   = ST_FILL;
            pix_cnt_next = '0;
          end
        end
        ST_FILL: begin
          if (push) begin
            pix_cnt_next = pix_cnt + CW'(1);
            if (pix_cnt + CW'(1) == CW'(H_VISIBLE)) begin
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    level_next    = wr_ptr_next - rd_ptr_next;
    line_req_next = (state_next == ST_REQ);
    in_ready_next = (state_next == ST_FILL) && (level_next != LW'(FIFO_DEPTH));

    if (!video_den) begin
      out_data_next = '0;
    end else if (fifo_empty) begin
      out_data_next = UNDERFLOW_RGB;
    end else begin
      out_data_next = mem[rd_ptr[AW-1:0]];
    end
    // A new underflow takes priority over a clear in the same cycle
    underflow_next = (video_den & fifo_empty) | (underflow & ~underflow_clr);
  end

  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      line_req   <= 1'b0;
      line_req_y <= '0;
      in_ready   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      vs_prev    <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_den    <= 1'b0;
      out_data   <= '0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_next;
      pix_cnt    <= pix_cnt_next;
      line_cnt   <= line_cnt_next;
      line_req   <= line_req_next;
      line_req_y <= line_req_y_next;
      in_ready   <= in_ready_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      fifo_level <= level_next;
      vs_prev    <= vs_active;
      out_hsync  <= video_hsync;
      out_vsync  <= video_vsync;
      out_den    <= video_den;
      out_data   <= out_data_next;
      underflow  <= underflow_next;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers
  always_ff @(posedge pixel_clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch (H_VISIBLE=8, FIFO_DEPTH=16) with a
// scoreboard-driven random-gap phase at the end.
module tb_video_line_fetch;

  localparam int unsigned PIXEL_W = 24;
  localparam logic [23:0] UF_RGB  = 24'hFF00FF;

  logic        pixel_clock;
  logic        rst;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_den;
  logic        video_line_start;
  logic        line_req;
  logic [13:0] line_req_y;
  logic        line_req_ack;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_den;
  logic [23:0] out_data;
  logic        underflow;
  logic        underflow_clr;
  logic [4:0]  fifo_level;

  int          n_checks;
  int          n_pass;

  video_line_fetch #(
    .PIXEL_W    (PIXEL_W),
    .H_VISIBLE  (8),
    .FIFO_DEPTH (16),
    .VSYNC_POL  (1'b1)
  ) dut (
    .pixel_clock      (pixel_clock),
    .rst              (rst),
    .video_hsync      (video_hsync),
    .video_vsync      (video_vsync),
    .video_den        (video_den),
    .video_line_start (video_line_start),
    .line_req         (line_req),
    .line_req_y       (line_req_y),
    .line_req_ack     (line_req_ack),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .out_hsync        (out_hsync),
    .out_vsync        (out_vsync),
    .out_den          (out_den),
    .out_data         (out_data),
    .underflow        (underflow),
    .underflow_clr    (underflow_clr),
    .fifo_level       (fifo_level)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge pixel_clock);
    #1;
  endtask

  initial begin
    logic [23:0] q[$];
    logic [23:0] exp_pix;
    logic        den_now;
    logic [23:0] next_val;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    video_hsync = 1'b0; video_vsync = 1'b0; video_den = 1'b0; video_line_start = 1'b0;
    line_req_ack = 1'b0; in_valid = 1'b0; in_data = '0; underflow_clr = 1'b0;
    repeat (2) @(posedge pixel_clock);
    #1 rst = 1'b0;
    step();

    // Reset state
    check("rst_line_req", 32'(line_req), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Test 1: request, ack after 3 cycles, 8 back-to-back pixels
    video_line_start = 1'b1;
    step();
    video_line_start = 1'b0;
    check("t1_req", 32'(line_req), 32'd1);
    check("t1_y", 32'(line_req_y), 32'd0);
    step(); step();
    check("t1_req_held", 32'(line_req), 32'd1);
    line_req_ack = 1'b1;
    step();
    line_req_ack = 1'b0;
    check("t1_req_drop", 32'(line_req), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check("t1_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 24'(i);
      step();
    end
    in_valid = 1'b0;
    check("t1_ready_drop", 32'(in_ready), 32'd0);
    check("t1_level", 32'(fifo_level), 32'd8);

    // Test 2: drain 8 pixels; sync/den delayed by one cycle
    for (int i = 0; i < 8; i++) begin
      video_den   = 1'b1;
      video_hsync = i[0];
      step();
      check("t2_den", 32'(out_den), 32'd1);
      check("t2_hsync", 32'(out_hsync), 32'(i[0]));
      check("t2_data", 32'(out_data), 32'(i + 1));
    end
    video_den = 1'b0; video_hsync = 1'b0;
    step();
    check("t2_den_low", 32'(out_den), 32'd0);
    check("t2_data_zero", 32'(out_data), 32'd0);
    check("t2_no_underflow", 32'(underflow), 32'd0);
    check("t2_level", 32'(fifo_level), 32'd0);

    // Test 3: underflow on empty FIFO, sticky, then cleared
    video_den = 1'b1;
    step();
    video_den = 1'b0;
    check("t3_uf_pixel", 32'(out_data), 32'(UF_RGB));
    check("t3_uf_set", 32'(underflow), 32'd1);
    step();
    check("t3_uf_held", 32'(underflow), 32'd1);
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    check("t3_uf_clr", 32'(underflow), 32'd0);

    // Test 4: line counter is 1 now; request y=1, extra line_start during FILL bumps it to 3
    video_line_start = 1'b1;
    step();
    video_line_start = 1'b0;
    check("t4_y1", 32'(line_req_y), 32'd1);
    line_req_ack = 1'b1;
    step();
    line_req_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 24'h11 + 24'(i);
      step();
    end
    in_valid = 1'b0;
    video_line_start = 1'b1;
    step();
    video_line_start = 1'b0;
    check("t4_no_req_in_fill", 32'(line_req), 32'd0);
    for (int i = 3; i < 8; i++) begin
      check("t4_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 24'h11 + 24'(i);
      step();
    end
    in_valid = 1'b0;
    check("t4_level", 32'(fifo_level), 32'd8);
    video_line_start = 1'b1;
    step();
    video_line_start = 1'b0;
    check("t4_req", 32'(line_req), 32'd1);
    check("t4_y3", 32'(line_req_y), 32'd3);

    // Test 5: pop 3 leaving 5 buffered with FSM in REQ, then vsync edge flushes
    for (int i = 0; i < 3; i++) begin
      video_den = 1'b1;
      step();
      check("t5_data", 32'(out_data), 32'h11 + 32'(i));
    end
    video_den = 1'b0;
    check("t5_level5", 32'(fifo_level), 32'd5);
    check("t5_in_req", 32'(line_req), 32'd1);
    video_vsync = 1'b1;
    step();
    check("t5_flush_level", 32'(fifo_level), 32'd0);
    check("t5_flush_req", 32'(line_req), 32'd0);
    check("t5_out_vsync", 32'(out_vsync), 32'd1);
    step();
    video_vsync = 1'b0;
    step();
    video_line_start = 1'b1;
    step();
    video_line_start = 1'b0;
    check("t5_req_after", 32'(line_req), 32'd1);
    check("t5_y0", 32'(line_req_y), 32'd0);

    // Test 6: random valid gaps, acks and pops against a scoreboard
    next_val = 24'h000100;
    for (int c = 0; c < 400; c++) begin
      video_line_start = (c % 12 == 0);
      line_req_ack     = line_req & 1'($urandom_range(0, 1));
      in_valid         = 1'($urandom_range(0, 2) != 0);
      in_data          = next_val;
      den_now          = 1'($urandom_range(0, 4) < 3);
      video_den        = den_now;
      exp_pix          = 24'd0;
      if (den_now) begin
        if (q.size() != 0) exp_pix = q.pop_front();
        else               exp_pix = UF_RGB;
      end
      if (in_valid && in_ready) begin
        q.push_back(next_val);
        next_val = next_val + 24'd1;
      end
      step();
      check("t6_data", 32'(out_data), 32'(exp_pix));
      check("t6_level", 32'(fifo_level), 32'(q.size()));
      check("t6_level_max", 32'(fifo_level <= 5'd16), 32'd1);
    end
    video_line_start = 1'b0; line_req_ack = 1'b0; in_valid = 1'b0; video_den = 1'b0;

    // Asynchronous reset mid-operation
    video_den = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_out_den", 32'(out_den), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    check("arst_line_req", 32'(line_req), 32'd0);
    video_den = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
